aes_req_arbiter: RTL and testbench
==================================

AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, gives the max cycles spent in WAIT_CT before the arbiter aborts the job.
REQ-002 Parameter NREQ, default 2, gives the number of requesters and is fixed at 2 for this revision.
REQ-003 clk  in  1  global clock; all state updates on rising edge.
REQ-004 resetN  in  1  asynchronous active-low reset.
REQ-005 rq_valid  in  2  per-requester job request; bit i belongs to requester i.
REQ-006 rq_newkey  in  2  bit i set: requester i's key must be (re)loaded into the core.
REQ-007 rq_key  in  256  keys; bits [128i+127:128i] belong to requester i.
REQ-008 rq_pt  in  256  plaintext blocks, packed the same way as rq_key.
REQ-009 rq_ready  out  2  one-cycle accept pulse to requester i; job is captured on that cycle.
REQ-010 rsp_valid  out  2  bit i high while a result for requester i is presented.
REQ-011 rsp_ack  in  2  requester i consumes its result when rsp_valid[i] and rsp_ack[i] are both high.
REQ-012 rsp_ct  out  128  ciphertext result.
REQ-013 rsp_err  out  1  result is a timeout abort; rsp_ct is then all zeros.
REQ-014 key_valid / key_ready / key_data  out/in/out  1/1/128  key load handshake to the AES core.
REQ-015 pt_valid / pt_ready / pt_data  out/in/out  1/1/128  plaintext handshake to the AES core.
REQ-016 ct_valid / ct_ready / ct_data  in/out/in  1/1/128  ciphertext handshake from the AES core.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD_KEY, SEND_PT, WAIT_CT and RETURN, with one job in flight at a time.
REQ-018 In IDLE with any rq_valid bit set, the FSM SHALL grant by round-robin: the winner is the lowest index other than last_grant if that requester is valid, else the other requester.
REQ-019 On the grant cycle: rq_ready[g] pulses, key, pt and newkey are latched internally, and last_grant<=g.
REQ-020 Key reuse: if key_owner_valid, key_owner==g and the latched newkey is 0, the FSM SHALL go IDLE->SEND_PT; otherwise it SHALL go IDLE->LOAD_KEY.
REQ-021 In LOAD_KEY, key_valid is high with the latched key and stays stable until key_ready.
  - On handshake: key_owner<=g, key_owner_valid<=1, next state SEND_PT.
REQ-022 In SEND_PT, pt_valid is high with the latched plaintext and stays stable until pt_ready; on handshake the timeout counter is cleared and the next state is WAIT_CT.
REQ-023 In WAIT_CT, ct_ready is held high.
  - ct_valid: latch ct_data and set err=0, next state RETURN.
  - Counter reaching TIMEOUT-1 without ct_valid: set err=1, result 0, key_owner_valid<=0, next state RETURN.
REQ-024 In RETURN, rsp_valid[g] is high with rsp_ct and rsp_err stable; on rsp_ack[g] the FSM SHALL return to IDLE.
  - rsp_ack on the non-granted bit SHALL be ignored.
REQ-025 ct_ready SHALL be 0 outside WAIT_CT; a ct_valid arriving in any other state is ignored.
REQ-026 Minimum job latency with zero-wait core handshakes: grant to rsp_valid = 3 cycles with key load, 2 cycles on key reuse, plus the core's compute cycles.
REQ-027 If both requesters are valid continuously, grants SHALL strictly alternate.
REQ-028 Requests are only sampled in IDLE; a deassertion of rq_valid after grant does not cancel the job.
REQ-029 The timeout counter SHALL be 7 bits wide, saturate, and never wrap.

Reset
REQ-030 While resetN=0, regardless of clk, the block SHALL force:
  - state=IDLE;
  - all valid/ready outputs 0;
  - rsp_ct=0, rsp_err=0, key_data=0, pt_data=0;
  - last_grant=1, so requester 0 wins first;
  - key_owner_valid=0;
  - counter=0.
REQ-031 A reset asserted mid-job SHALL discard the job, and after release the first job SHALL perform a full key load.

Verification
REQ-032 Single job: rq_valid=01, newkey=01, FIPS-197 key 000102..0f, pt 00112233..ff.
  - Required: a key handshake, then a pt handshake, then rsp_valid=01 with ct 69c4e0d86a7b0430d8cdb78070b4c55a and rsp_err=0.
REQ-033 Key reuse: repeat the REQ-032 job from requester 0 with newkey=0.
  - Required: no key_valid pulse, same ciphertext, grant-to-rsp_valid one cycle shorter.
REQ-034 Contention: rq_valid=11 held for 4 jobs.
  - Required: grant order 0,1,0,1, with a key load on every job since the owner changes.
REQ-035 Timeout: the core never raises ct_valid.
  - Required: rsp_valid after exactly TIMEOUT cycles in WAIT_CT, rsp_err=1, rsp_ct=0.
  - Required: the next job reloads the key.
REQ-036 Reset in WAIT_CT: drop resetN for 1 cycle.
  - Required: all outputs reach reset values immediately.
  - Required: a subsequent job with newkey=0 still performs LOAD_KEY.
REQ-037 Backpressure: key_ready and pt_ready are held low for 5 cycles.
  - Required: key_data and pt_data are stable and valid stays high throughout.
  - Required: no duplicate handshake occurs.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter that shares one AES core between two requesters.
// It skips the key load when the core already holds the winner's key, and aborts a job whose ciphertext never arrives.
module aes_req_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int NREQ    = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [NREQ-1:0]      rq_valid,
  input  logic [NREQ-1:0]      rq_newkey,
  input  logic [NREQ*128-1:0]  rq_key,
  input  logic [NREQ*128-1:0]  rq_pt,
  output logic [NREQ-1:0]      rq_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ack,
  output logic [127:0]         rsp_ct,
  output logic                 rsp_err,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [127:0]         key_data,
  output logic                 pt_valid,
  input  logic                 pt_ready,
  output logic [127:0]         pt_data,
  input  logic                 ct_valid,
  output logic                 ct_ready,
  input  logic [127:0]         ct_data
);

  typedef enum logic [2:0] {IDLE, LOAD_KEY, SEND_PT, WAIT_CT, RETURN} state_e;

  localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

  state_e       state_q, state_d;
  logic         grant_q, grant_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q, owner_d;
  logic         owner_vld_q, owner_vld_d;
  logic [127:0] key_q, key_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] ct_q, ct_d;
  logic         err_q, err_d;
  logic [6:0]   cnt_q, cnt_d;
  logic         win;
  logic         grant_en;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v == 7'h7f) ? v : v + 7'd1;
  endfunction

  // Prefer the requester that did not win last time; fall back to the other one.
  always_comb begin
    win = ~last_grant_q;
    if (!rq_valid[win]) win = last_grant_q;
  end

  assign grant_en = (state_q == IDLE) && (|rq_valid);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    owner_vld_d  = owner_vld_q;
    key_d        = key_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_en) begin
          grant_d      = win;
          last_grant_d = win;
          key_d        = win ? rq_key[255:128] : rq_key[127:0];
          pt_d         = win ? rq_pt[255:128]  : rq_pt[127:0];
          if (owner_vld_q && (owner_q == win) && !rq_newkey[win]) state_d = SEND_PT;
          else                                                     state_d = LOAD_KEY;
        end
      end
      LOAD_KEY: begin
        if (key_ready) begin
          owner_d     = grant_q;
          owner_vld_d = 1'b1;
          state_d     = SEND_PT;
        end
      end
      SEND_PT: begin
        if (pt_ready) begin
          cnt_d   = '0;
          state_d = WAIT_CT;
        end
      end
      WAIT_CT: begin
        // A ciphertext arriving on the last allowed cycle still counts as a result.
        if (ct_valid) begin
          ct_d    = ct_data;
          err_d   = 1'b0;
          state_d = RETURN;
        end else if (cnt_q >= CNT_LAST) begin
          ct_d        = '0;
          err_d       = 1'b1;
          owner_vld_d = 1'b0;
          state_d     = RETURN;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      RETURN: begin
        if (rsp_ack[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      owner_vld_q  <= 1'b0;
      key_q        <= '0;
      pt_q         <= '0;
      ct_q         <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      owner_vld_q  <= owner_vld_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // rq_ready is combinational on rq_valid, so it is also gated by reset directly.
  assign rq_ready  = {win, ~win} & {NREQ{grant_en & resetN}};
  assign rsp_valid = {grant_q, ~grant_q} & {NREQ{state_q == RETURN}};
  assign rsp_ct    = ct_q;
  assign rsp_err   = err_q;
  assign key_valid = (state_q == LOAD_KEY);
  assign key_data  = key_q;
  assign pt_valid  = (state_q == SEND_PT);
  assign pt_data   = pt_q;
  assign ct_ready  = (state_q == WAIT_CT);

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: a behavioural AES-core stand-in plus a job-level reference model
// (round-robin pick, key ownership, latency and result prediction) covering directed and random jobs.
`timescale 1ns/1ps
module tb_aes_req_arbiter;
  localparam int TO = 40;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] P1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  logic         clk = 1'b0;
  logic         resetN;
  logic [1:0]   rq_valid, rq_newkey, rq_ready, rsp_valid, rsp_ack;
  logic [255:0] rq_key, rq_pt;
  logic [127:0] rsp_ct, key_data, pt_data, ct_data;
  logic         rsp_err, key_valid, key_ready, pt_valid, pt_ready, ct_valid, ct_ready;

  aes_req_arbiter #(.TIMEOUT(TO), .NREQ(2)) dut (
    .clk(clk), .resetN(resetN),
    .rq_valid(rq_valid), .rq_newkey(rq_newkey), .rq_key(rq_key), .rq_pt(rq_pt),
    .rq_ready(rq_ready), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .rsp_ct(rsp_ct), .rsp_err(rsp_err),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stand-in cipher: the FIPS-197 vector maps to its known ciphertext, anything else to a keyed mix.
  function automatic logic [127:0] toy(input logic [127:0] k, input logic [127:0] p);
    if (k == FK && p == FP) return FC;
    return k ^ {p[63:0], p[127:64]} ^ 128'ha5a50f0f_3c3c5a5a_c3c3f0f0_12348765;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core stand-in: programmable stalls, ciphertext delay, or no answer at all.
  int           key_stall = 0, pt_stall = 0, ct_delay = 0;
  bit           ct_never = 0;
  int           nkey_hs = 0, npt_hs = 0;
  bit           unstable = 0, ctr_bad = 0, busy = 0;
  int           kw = 0, pw = 0, cw = 0;
  logic [127:0] core_key = '0, core_pt = '0, hold_k = '0, hold_p = '0;

  initial begin
    key_ready = 1'b0; pt_ready = 1'b0; ct_valid = 1'b0; ct_data = '0;
    forever begin
      @(negedge clk);
      ct_valid = 1'b0;
      if ((key_valid || pt_valid) && ct_ready) ctr_bad = 1;
      if (busy && !ct_never && ct_ready) begin
        if (cw >= ct_delay) begin
          ct_valid = 1'b1; ct_data = toy(core_key, core_pt); busy = 0;
        end else cw++;
      end
      if (key_valid) begin
        if (kw == 0) hold_k = key_data; else if (key_data !== hold_k) unstable = 1;
        if (kw >= key_stall) begin
          key_ready = 1'b1; core_key = key_data; nkey_hs++; kw = 0;
        end else begin
          key_ready = 1'b0; kw++;
        end
      end else begin
        key_ready = 1'b0; kw = 0;
      end
      if (pt_valid) begin
        if (pw == 0) hold_p = pt_data; else if (pt_data !== hold_p) unstable = 1;
        if (pw >= pt_stall) begin
          pt_ready = 1'b1; core_pt = pt_data; npt_hs++; pw = 0; busy = 1; cw = 0;
        end else begin
          pt_ready = 1'b0; pw++;
        end
      end else begin
        pt_ready = 1'b0; pw = 0;
      end
    end
  end

  // Reference model state at job granularity.
  bit           m_last, m_owner, m_ovld;
  logic [127:0] m_core_key;
  bit           dut_g;

  task automatic do_job(input string tag, input logic [1:0] v, input logic [1:0] nk,
                        input logic [255:0] k, input logic [255:0] p, input bit keep,
                        input int ks, input int ps, input int cd, input bit never);
    bit pref, g, load, tmo;
    int wait_cyc, exp_lat, lat, n, k0, p0;
    logic [127:0] gk, gp, exp_ct;
    pref = ~m_last;
    g    = v[pref] ? pref : m_last;
    load = !(m_ovld && (m_owner == g) && !nk[g]);
    gk   = g ? k[255:128] : k[127:0];
    gp   = g ? p[255:128] : p[127:0];
    if (load) m_core_key = gk;
    tmo      = never || (cd + 1 > TO);
    wait_cyc = tmo ? TO : cd + 1;
    exp_ct   = tmo ? '0 : toy(m_core_key, gp);
    exp_lat  = (load ? 1 + ks : 0) + 1 + ps + wait_cyc;

    key_stall = ks; pt_stall = ps; ct_delay = cd; ct_never = never;
    k0 = nkey_hs; p0 = npt_hs;
    rq_valid = v; rq_newkey = nk; rq_key = k; rq_pt = p;
    #1;
    n = 0;
    while (rq_ready === 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    chk({tag, ".grant"}, 128'(rq_ready), g ? 128'd2 : 128'd1);
    dut_g = rq_ready[1];
    @(negedge clk);
    if (!keep) rq_valid = 2'b00;
    #1;
    lat = 0;
    while (rsp_valid === 2'b00 && lat < TO + 40) begin @(negedge clk); #1; lat++; end
    chk({tag, ".latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, ".rsp_valid"}, 128'(rsp_valid), g ? 128'd2 : 128'd1);
    chk({tag, ".rsp_ct"}, rsp_ct, exp_ct);
    chk({tag, ".rsp_err"}, 128'(rsp_err), 128'(tmo));
    chk({tag, ".key_hs"}, 128'(nkey_hs - k0), load ? 128'd1 : 128'd0);
    chk({tag, ".pt_hs"}, 128'(npt_hs - p0), 128'd1);
    chk({tag, ".ct_ready_ret"}, 128'(ct_ready), 128'd0);
    @(negedge clk);
    rsp_ack = g ? 2'b01 : 2'b10;
    @(negedge clk); #1;
    chk({tag, ".wrong_ack_hold"}, 128'(rsp_valid), g ? 128'd2 : 128'd1);
    chk({tag, ".ct_stable"}, rsp_ct, exp_ct);
    rsp_ack = g ? 2'b10 : 2'b01;
    @(negedge clk); #1;
    rsp_ack = 2'b00;
    chk({tag, ".released"}, 128'(rsp_valid), 128'd0);

    m_last = g;
    if (load) begin m_owner = g; m_ovld = 1; end
    if (tmo) m_ovld = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [127:0] rk [2];
  logic [1:0]   pend, rv;
  logic [255:0] rpt;
  int           n;

  initial begin
    resetN = 1'b0; rq_valid = 2'b11; rq_newkey = '0; rq_key = '0; rq_pt = '0; rsp_ack = '0;
    m_last = 1; m_owner = 0; m_ovld = 0; m_core_key = '0; dut_g = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.rq_ready", 128'(rq_ready), 128'd0);
    chk("reset.rsp_valid", 128'(rsp_valid), 128'd0);
    chk("reset.key_valid", 128'(key_valid), 128'd0);
    chk("reset.pt_valid", 128'(pt_valid), 128'd0);
    chk("reset.ct_ready", 128'(ct_ready), 128'd0);
    chk("reset.rsp_ct", rsp_ct, 128'd0);
    resetN = 1'b1; rq_valid = 2'b00;
    @(negedge clk); #1;

    do_job("fips", 2'b01, 2'b01, {128'd0, FK}, {128'd0, FP}, 0, 0, 0, 2, 0);
    chk("fips.ct_vector", rsp_ct, FC);
    do_job("reuse", 2'b01, 2'b00, {128'd0, FK}, {128'd0, FP}, 0, 0, 0, 2, 0);
    chk("reuse.ct_vector", rsp_ct, FC);

    unstable = 0;
    do_job("bp", 2'b10, 2'b10, {K1, 128'd0}, {P1, 128'd0}, 0, 5, 5, 1, 0);
    chk("bp.stable", 128'(unstable), 128'd0);

    for (int i = 0; i < 4; i++) begin
      do_job("cont", 2'b11, 2'b00, {K1, FK}, {P1, FP}, i < 3, 0, 0, 0, 0);
      chk("cont.order", 128'(dut_g), 128'(i % 2));
    end

    do_job("tmo", 2'b01, 2'b00, {K1, FK}, {P1, FP}, 0, 0, 0, 0, 1);
    do_job("after_tmo", 2'b01, 2'b00, {K1, FK}, {P1, FP}, 0, 0, 0, 0, 0);
    do_job("edge_ok", 2'b01, 2'b00, {K1, FK}, {P1, FP}, 0, 0, 0, TO - 1, 0);
    do_job("edge_tmo", 2'b01, 2'b00, {K1, FK}, {P1, FP}, 0, 0, 0, TO, 0);
    do_job("pre_rst", 2'b01, 2'b00, {K1, FK}, {P1, FP}, 0, 0, 0, 0, 0);

    key_stall = 0; pt_stall = 0; ct_never = 1;
    rq_valid = 2'b01; rq_newkey = 2'b00; rq_key = {K1, FK}; rq_pt = {P1, FP};
    #1;
    n = 0;
    while (ct_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    chk("rst.reach_wait", 128'(ct_ready), 128'd1);
    resetN = 1'b0;
    #1;
    chk("rst.rq_ready", 128'(rq_ready), 128'd0);
    chk("rst.rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst.key_valid", 128'(key_valid), 128'd0);
    chk("rst.pt_valid", 128'(pt_valid), 128'd0);
    chk("rst.ct_ready", 128'(ct_ready), 128'd0);
    chk("rst.rsp_ct", rsp_ct, 128'd0);
    chk("rst.rsp_err", 128'(rsp_err), 128'd0);
    chk("rst.key_data", key_data, 128'd0);
    chk("rst.pt_data", pt_data, 128'd0);
    @(negedge clk);
    resetN = 1'b1; rq_valid = 2'b00; ct_never = 0;
    m_last = 1; m_ovld = 0;
    #1;
    do_job("post_rst", 2'b01, 2'b00, {K1, FK}, {P1, FP}, 0, 0, 0, 1, 0);

    rk[0] = FK; rk[1] = K1; pend = 2'b00;
    for (int i = 0; i < 14; i++) begin
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 2) == 0) begin
          rk[r] = {$urandom, $urandom, $urandom, $urandom};
          pend[r] = 1'b1;
        end
      end
      rv  = 2'($urandom_range(1, 3));
      rpt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_job("rnd", rv, pend, {rk[1], rk[0]}, rpt, 0, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 6)), $urandom_range(0, 5) == 0);
      pend[m_last] = 1'b0;
    end

    chk("ct_ready_outside_wait", 128'(ctr_bad), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
